restoring_divider: RTL and testbench
====================================

# restoring_divider

Multi-cycle unsigned integer divider, the inverse of the team's lookahead adders. It computes quotient and remainder one bit per clock with a restoring shift-subtract algorithm. The trial subtraction is a two's-complement add, A + ~B + 1, built from 4-bit carry-lookahead groups chained through group generate/propagate. It sits beside the adder blocks as the datapath's divide unit and is driven by a start/done handshake.

## Interface
- Width, 8, operand/result width in bits; must be a multiple of 4 and at least 4.
- Clock  input  1  single clock; all state changes on the rising edge.
- ResetN  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled on the rising edge, accepted only in IDLE or DONE.
- Dividend  input  Width  unsigned dividend; sampled when Start is accepted.
- Divisor  input  Width  unsigned divisor; sampled when Start is accepted.
- Busy  output  1  high while in RUN.
- Done  output  1  one-cycle pulse; high while in DONE.
- Quotient  output  Width  registered result; held until the next completion.
- Remainder  output  Width  registered result; held until the next completion.
- DivideByZero  output  1  registered flag for the last completed operation.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- Reset values: Busy=0, Done=0, Quotient=0, Remainder=0, DivideByZero=0, iteration counter=0, all internal working registers=0.
- IDLE with Start=1:
  - Latch Dividend into the shift register Q and Divisor into D.
  - Clear the partial remainder R (Width+1 bits) and the counter.
  - If Divisor==0, go to DONE. Otherwise go to RUN.
- RUN, one iteration per edge:
  - Form T = {R[Width-1:0], Q[Width-1]} (Width+1 bits) and compute S = T - {1'b0, D} through the lookahead subtractor.
  - If carry-out=1 (no borrow): R←S and shift 1 into Q's LSB.
  - Otherwise: R←T and shift 0 into Q's LSB.
  - Q shifts left by one each iteration. Counter increments.
  - After the Width-th iteration, go to DONE.
- Entering DONE updates the outputs:
  - Normal case: Quotient←Q, Remainder←R[Width-1:0], DivideByZero←0.
  - Divide-by-zero case: Quotient←all ones, Remainder←latched Dividend, DivideByZero←1.
- DONE:
  - Done=1 for exactly one cycle.
  - If Start=1, accept a new operation exactly as from IDLE (back-to-back). Otherwise go to IDLE.
- Start in RUN is ignored. Dividend and Divisor may change freely after acceptance.
- Quotient, Remainder and DivideByZero never show intermediate values; they change only on entry to DONE.
- Subtractor:
  - Built from Width/4+1 lookahead groups; the top group uses only bit 0.
  - Carry-in = 1.
  - Inter-group carry uses group generate/propagate, not ripple through all bits.

## Timing
- Latency, Divisor≠0:
  - Start accepted at edge 0. Busy=1 in the cycles after edges 0..Width-1.
  - Edge Width enters DONE; Done=1 in the cycle after edge Width, with results valid in the same cycle.
- Latency, Divisor==0: edge 0 enters DONE directly; Done=1 in the cycle after edge 0.
- Throughput:
  - Back-to-back via Start in DONE gives one result per Width+1 cycles.
  - Via IDLE gives one result per Width+2 cycles.
- Busy and Done are never high together.
- Reset asserted mid-RUN:
  - Outputs go to their reset values immediately, without waiting for a clock.
  - The operation is abandoned and no Done pulse occurs.
- Deasserting ResetN with Start=1: Start is accepted on the first rising edge where ResetN is already high.
- Operands: max Dividend (all ones) with Divisor=1 must not overflow R. The Width+1-bit T guarantees this.

## Test plan
- Width=8, Start with 100/7 -> Busy for 8 cycles, then Done=1 for one cycle with Quotient=14, Remainder=2, DivideByZero=0.
- 255/1, then 5/9, then 255/255 -> (255,0), (0,5), (1,0); each Done exactly 8 cycles after its Start edge.
- 37/0 -> Done in the cycle after the Start edge, Quotient=255, Remainder=37, DivideByZero=1, Busy never high.
- 200/3 accepted; Start pulsed with 9/2 while Busy -> ignored; result is (66,2) and no second Done follows.
- Start held high continuously with 50/6 then 81/9 presented at each acceptance -> Done pulses 9 cycles apart, results (8,2) then (9,0).
- ResetN pulled low 4 cycles into 180/11 -> outputs zero asynchronously, no Done. Afterwards 180/11 -> (16,4).

Source files
------------

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, trial
// subtraction through a carry-lookahead subtractor, start/done handshake.
module restoring_divider #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_by_zero_o
);

   localparam int unsigned NG = WIDTH / 4 + 1;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   t;
   logic [WIDTH:0]   sub_a, sub_b, sub_g, sub_p, sub_s;
   logic [WIDTH+1:0] bit_c;
   logic [NG-2:0]    grp_g, grp_p;
   logic [NG-1:0]    grp_c;
   logic             no_borrow;

   // R stays below D, so its MSB is always zero and only feeds this sink.
   logic unused_r_msb;
   assign unused_r_msb = r_q[WIDTH];

   // T - {0,D} as T + ~{0,D} + 1; full 4-bit groups below bit WIDTH, the
   // top group holds only bit WIDTH, group carries come from group G/P.
   always_comb begin
      t      = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
      sub_a  = t;
      sub_b  = ~{1'b0, d_q};
      sub_g  = sub_a & sub_b;
      sub_p  = sub_a ^ sub_b;
      grp_g  = '0;
      grp_p  = '0;
      grp_c  = '0;
      bit_c  = '0;
      grp_c[0] = 1'b1;
      for (int unsigned k = 0; k < NG - 1; k++) begin
         grp_g[k] = sub_g[4*k+3]
                  | (sub_p[4*k+3] & sub_g[4*k+2])
                  | (sub_p[4*k+3] & sub_p[4*k+2] & sub_g[4*k+1])
                  | (sub_p[4*k+3] & sub_p[4*k+2] & sub_p[4*k+1] & sub_g[4*k]);
         grp_p[k] = &sub_p[4*k +: 4];
         grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
         bit_c[4*k]   = grp_c[k];
         bit_c[4*k+1] = sub_g[4*k] | (sub_p[4*k] & grp_c[k]);
         bit_c[4*k+2] = sub_g[4*k+1]
                      | (sub_p[4*k+1] & sub_g[4*k])
                      | (sub_p[4*k+1] & sub_p[4*k] & grp_c[k]);
         bit_c[4*k+3] = sub_g[4*k+2]
                      | (sub_p[4*k+2] & sub_g[4*k+1])
                      | (sub_p[4*k+2] & sub_p[4*k+1] & sub_g[4*k])
                      | (sub_p[4*k+2] & sub_p[4*k+1] & sub_p[4*k] & grp_c[k]);
      end
      bit_c[WIDTH]   = grp_c[NG-1];
      bit_c[WIDTH+1] = sub_g[WIDTH] | (sub_p[WIDTH] & bit_c[WIDTH]);
      sub_s     = sub_p ^ bit_c[WIDTH:0];
      no_borrow = bit_c[WIDTH+1];
   end

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      d_d     = d_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               q_d   = dividend_i;
               d_d   = divisor_i;
               r_d   = '0;
               cnt_d = '0;
               if (divisor_i == '0) begin
                  state_d = S_DONE;
                  quot_d  = '1;
                  rem_d   = dividend_i;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            r_d   = no_borrow ? sub_s : t;
            q_d   = {q_q[WIDTH-2:0], no_borrow};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_DONE;
               quot_d  = q_d;
               rem_d   = r_d[WIDTH-1:0];
               dbz_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         q_q     <= '0;
         d_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         d_q     <= d_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy_o        = (state_q == S_RUN);
   assign done_o        = (state_q == S_DONE);
   assign quotient_o    = quot_q;
   assign remainder_o   = rem_q;
   assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Bench for restoring_divider: arithmetic reference model checked every cycle
// plus directed operations with hand-computed results and latencies.
module tb_restoring_divider;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done, dbz;
   logic [W-1:0] quot, rem;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;

   restoring_divider #(.WIDTH(W)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .dividend_i   (dividend),
      .divisor_i    (divisor),
      .busy_o       (busy),
      .done_o       (done),
      .quotient_o   (quot),
      .remainder_o  (rem),
      .div_by_zero_o(dbz)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: cycles left until a result appears, and that pending result.
   int           m_left;
   logic         m_done, m_z;
   logic [W-1:0] m_q, m_r, p_q, p_r;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left <= 0;
         m_done <= 1'b0;
         m_q    <= '0;
         m_r    <= '0;
         m_z    <= 1'b0;
         p_q    <= '0;
         p_r    <= '0;
      end else begin
         m_done <= 1'b0;
         if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_done <= 1'b1;
               m_q    <= p_q;
               m_r    <= p_r;
               m_z    <= 1'b0;
            end
         end else if (start) begin
            if (divisor == 0) begin
               m_done <= 1'b1;
               m_q    <= '1;
               m_r    <= dividend;
               m_z    <= 1'b1;
            end else begin
               m_left <= W;
               p_q    <= dividend / divisor;
               p_r    <= dividend % divisor;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (done) done_cnt++;
      check("busy", {31'd0, busy}, {31'd0, m_left > 0});
      check("done", {31'd0, done}, {31'd0, m_done});
      check("quotient", {24'd0, quot}, {24'd0, m_q});
      check("remainder", {24'd0, rem}, {24'd0, m_r});
      check("dbz", {31'd0, dbz}, {31'd0, m_z});
      check("busy_and_done", {31'd0, busy & done}, 32'd0);
   end

   // Called at the negedge right after the accepting edge.
   task automatic wait_done(input string tag, output int lat, output int busy_cycles);
      bit seen;
      lat = 0;
      busy_cycles = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (busy) busy_cycles++;
            lat++;
            @(negedge clk);
         end
      end
      if (!seen) check({tag, " timeout"}, 32'd0, 32'd1);
   endtask

   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      dividend = 8'hA5;
      divisor  = 8'h5A;
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int eq, input int er,
                         input int ez, input int elat, input string tag);
      int lat, bc;
      @(negedge clk);
      launch(a, b);
      wait_done(tag, lat, bc);
      check({tag, " latency"}, lat, elat);
      check({tag, " busy_cycles"}, bc, elat);
      check({tag, " q"}, {24'd0, quot}, eq);
      check({tag, " r"}, {24'd0, rem}, er);
      check({tag, " z"}, {31'd0, dbz}, ez);
   endtask

   initial begin
      int lat, bc, dc;
      time t1;
      repeat (2) @(negedge clk);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset q", {24'd0, quot}, 32'd0);
      check("reset r", {24'd0, rem}, 32'd0);
      check("reset z", {31'd0, dbz}, 32'd0);
      rst_n = 1'b1;

      run_op(8'd100, 8'd7, 14, 2, 0, 8, "100/7");
      run_op(8'd255, 8'd1, 255, 0, 0, 8, "255/1");
      run_op(8'd5, 8'd9, 0, 5, 0, 8, "5/9");
      run_op(8'd255, 8'd255, 1, 0, 0, 8, "255/255");
      run_op(8'd37, 8'd0, 255, 37, 1, 0, "37/0");

      // Start pulsed while busy must be ignored.
      @(negedge clk);
      launch(8'd200, 8'd3);
      dc = done_cnt;
      fork
         wait_done("200/3", lat, bc);
         begin
            repeat (3) @(negedge clk);
            dividend = 8'd9;
            divisor  = 8'd2;
            start    = 1'b1;
            @(negedge clk);
            start    = 1'b0;
         end
      join
      check("200/3 latency", lat, 8);
      check("200/3 q", {24'd0, quot}, 66);
      check("200/3 r", {24'd0, rem}, 2);
      repeat (15) @(negedge clk);
      check("200/3 done pulses", done_cnt - dc, 1);

      // Start held high: second operation accepted straight from DONE.
      dividend = 8'd50;
      divisor  = 8'd6;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      wait_done("50/6", lat, bc);
      t1 = $time;
      check("50/6 latency", lat, 8);
      check("50/6 q", {24'd0, quot}, 8);
      check("50/6 r", {24'd0, rem}, 2);
      dividend = 8'd81;
      divisor  = 8'd9;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done("81/9", lat, bc);
      check("b2b spacing ns", int'($time - t1), 90);
      check("81/9 q", {24'd0, quot}, 9);
      check("81/9 r", {24'd0, rem}, 0);

      // Asynchronous reset in the middle of an operation.
      @(negedge clk);
      launch(8'd180, 8'd11);
      repeat (3) @(negedge clk);
      dc = done_cnt;
      #2 rst_n = 1'b0;
      #1;
      check("async rst busy", {31'd0, busy}, 32'd0);
      check("async rst done", {31'd0, done}, 32'd0);
      check("async rst q", {24'd0, quot}, 32'd0);
      check("async rst r", {24'd0, rem}, 32'd0);
      check("async rst z", {31'd0, dbz}, 32'd0);
      @(negedge clk);
      #3 rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("abandoned done pulses", done_cnt - dc, 0);

      // Start already high as reset releases: taken on the first clean edge.
      rst_n    = 1'b0;
      dividend = 8'd180;
      divisor  = 8'd11;
      start    = 1'b1;
      @(negedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done("180/11", lat, bc);
      check("180/11 latency", lat, 8);
      check("180/11 q", {24'd0, quot}, 16);
      check("180/11 r", {24'd0, rem}, 4);
      check("180/11 z", {31'd0, dbz}, 0);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
